// File: rtl/core_pkg.sv
// Shared integer-core constants and the register-address type.
// Also holds the one-hot decode used by the writeback scoreboard.
package core_pkg;

  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int NREGS = 32;

  typedef logic [AW-1:0] reg_addr_t;

  // x0 never gets a bit, so an access to it decodes to an empty mask.
  function automatic logic [NREGS-1:0] rd_onehot(input reg_addr_t rd);
    logic [NREGS-1:0] mask;
    mask = '0;
    if (rd != '0) mask[rd] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-result scoreboard: one bit per register with an outstanding
// long-latency result. Bit 0 is held at zero.
module wb_scoreboard
  import core_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  reg_addr_t        set_rd,
  input  logic             clr_en,
  input  reg_addr_t        clr_rd,
  input  reg_addr_t        iss_rd,
  input  reg_addr_t        ra1,
  input  reg_addr_t        ra2,
  output logic [NREGS-1:0] pending,
  output logic             iss_hit,
  output logic             ra1_hit,
  output logic             ra2_hit
);

  logic [NREGS-1:0] pending_reg;
  logic [NREGS-1:0] pending_next;
  logic [NREGS-1:0] set_mask;
  logic [NREGS-1:0] clr_mask;

  assign set_mask = set_en ? rd_onehot(set_rd) : '0;
  assign clr_mask = clr_en ? rd_onehot(clr_rd) : '0;

  // Clear dominates set on the same register; the stall logic keeps that
  // case from arising in normal operation.
  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_bit
      if (gi == 0) begin : g_zero
        assign pending_next[gi] = 1'b0;
      end else begin : g_live
        assign pending_next[gi] = (pending_reg[gi] | set_mask[gi]) & ~clr_mask[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) pending_reg <= '0;
    else     pending_reg <= pending_next;
  end

  assign pending = pending_reg;
  assign iss_hit = pending_reg[iss_rd];
  assign ra1_hit = pending_reg[ra1];
  assign ra2_hit = pending_reg[ra2];

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-port owner: arbitrates pipeline (A) and long-latency
// (B) writebacks, tracks outstanding B results and raises decode stalls.
module regfile_wb_ctrl
  import core_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [AW-1:0]    a_rd,
  input  logic [XLEN-1:0]  a_wd,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [AW-1:0]    b_rd,
  input  logic [XLEN-1:0]  b_wd,
  output logic             b_ready,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_rd,
  output logic             iss_stall,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  output logic             raw_stall,
  output logic             rf_we,
  output logic [AW-1:0]    rf_wa,
  output logic [XLEN-1:0]  rf_wd,
  output logic [NREGS-1:0] pending,
  output logic             err
);

  localparam int WW = 4;
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  logic [WW-1:0] wait_cnt_reg;
  logic [WW-1:0] wait_cnt_next;
  logic          err_reg;
  logic          err_next;

  logic prio_b;
  logic grant_a;
  logic grant_b;
  logic a_nz;
  logic b_nz;
  logic iss_hit;
  logic ra1_hit;
  logic ra2_hit;
  logic set_en;

  assign a_nz = (a_rd != '0);
  assign b_nz = (b_rd != '0);

  // Reset suppresses every grant so nothing reaches the regfile during rst.
  assign prio_b  = (wait_cnt_reg == WAIT_MAX);
  assign grant_a = !rst & a_valid & (!b_valid | !prio_b);
  assign grant_b = !rst & b_valid & !grant_a;
  assign a_ready = !rst & (grant_a | !a_valid);
  assign b_ready = !rst & (grant_b | !b_valid);

  assign rf_we = (grant_a & a_nz) | (grant_b & b_nz);
  assign rf_wa = grant_b ? b_rd : a_rd;
  assign rf_wd = grant_b ? b_wd : a_wd;

  assign iss_stall = !rst & iss_valid & iss_hit;
  assign raw_stall = !rst & (ra1_hit | ra2_hit);
  assign set_en    = iss_valid & !iss_stall;

  wb_scoreboard u_sb (
    .clk     (clk),
    .rst     (rst),
    .set_en  (set_en),
    .set_rd  (iss_rd),
    .clr_en  (grant_b),
    .clr_rd  (b_rd),
    .iss_rd  (iss_rd),
    .ra1     (ra1),
    .ra2     (ra2),
    .pending (pending),
    .iss_hit (iss_hit),
    .ra1_hit (ra1_hit),
    .ra2_hit (ra2_hit)
  );

  // Count cycles B has lost; once saturated B outranks A for one grant.
  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if (grant_b || !b_valid)
      wait_cnt_next = '0;
    else if (wait_cnt_reg != WAIT_MAX)
      wait_cnt_next = wait_cnt_reg + 1'b1;
  end

  // B completing an unissued register, or A overwriting a pending one,
  // means the issue/decode handshake was violated.
  always_comb begin
    err_next = err_reg;
    if (grant_b && b_nz && !pending[b_rd]) err_next = 1'b1;
    if (grant_a && a_nz &&  pending[a_rd]) err_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      wait_cnt_reg <= wait_cnt_next;
      err_reg      <= err_next;
    end
  end

  assign err = err_reg;

endmodule

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
- Owns the single write port of the 32x32 integer register file (x0 hard-wired zero, 2 async read ports, posedge write).
- Arbitrates between two writeback sources: A, the in-order pipeline WB stage (1-cycle ALU results), and B, the long-latency unit (mul/div/load, out-of-order completion).
- Keeps a scoreboard of registers with outstanding B results and raises hazard stalls for decode.
- Sits between decode/WB and regfile; drives the regfile we/wa/wd.

Parameters:
- XLEN, 32, data width
- AW, 5, register address width
- MAX_WAIT, 4, consecutive cycles B may lose arbitration before it takes priority (1..15)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- a_valid  in  1  pipeline WB has a result
- a_rd  in  AW  destination
- a_wd  in  XLEN  data
- a_ready  out  1  A write accepted this cycle; WB must hold when 0
- b_valid  in  1  long-latency unit has a result
- b_rd  in  AW  destination
- b_wd  in  XLEN  data
- b_ready  out  1  B write accepted this cycle
- iss_valid  in  1  decode issues a long-latency op
- iss_rd  in  AW  its destination
- iss_stall  out  1  issue blocked (WAW on pending rd)
- ra1, ra2  in  AW  decode source addresses
- raw_stall  out  1  a source is pending
- rf_we  out  1  to regfile we
- rf_wa  out  AW  to regfile wa
- rf_wd  out  XLEN  to regfile wd
- pending  out  32  scoreboard, bit 0 always 0
- err  out  1  sticky protocol error

Behaviour:
- Reset (rst=1 at posedge): pending=0, wait counter=0, err=0. While rst high, a_ready=b_ready=rf_we=0, iss_stall=raw_stall=0. Reset mid-transaction discards any outstanding B result; the owner of B must reset too.
- Arbitration is combinational, zero latency; the write lands in the regfile at the same posedge.
  - prio_b = (wait_cnt == MAX_WAIT).
  - grant_a = a_valid & (!b_valid | !prio_b).
  - grant_b = b_valid & !grant_a.
  - a_ready = grant_a | !a_valid; b_ready = grant_b | !b_valid.
- Write port:
  - rf_we = (grant_a & a_rd≠0) | (grant_b & b_rd≠0).
  - rf_wa/rf_wd are muxed from the winner. When idle they show A's values (don't-care).
  - A grant to x0 still consumes the slot.
- Wait counter: increments each cycle b_valid & !grant_b, saturating at MAX_WAIT. Clears to 0 on grant_b or when !b_valid.
- Scoreboard:
  - Set: pending[iss_rd] <= 1 when iss_valid & !iss_stall & iss_rd≠0.
  - Clear: pending[b_rd] <= 0 on grant_b.
  - Set and clear of different registers in the same cycle both take effect.
  - Same register set and cleared in one cycle cannot occur, because iss_stall blocks it. Clear wins if forced.
- Stalls (combinational from the registered pending):
  - iss_stall = iss_valid & pending[iss_rd].
  - raw_stall = pending[ra1] | pending[ra2].
  - No bypass: a source cleared by a B write at edge N is readable from the regfile in cycle N+1 with raw_stall=0.
- err (sticky until rst) sets on either:
  - grant_b with b_rd≠0 & !pending[b_rd];
  - grant_a with a_rd≠0 & pending[a_rd] (WAW escaped decode).
- No combinational path from a_ready/b_ready back to a_valid/b_valid. Sources must keep valid/rd/wd stable until ready.

Decomposition:
- Shared package core_pkg: XLEN, AW, NREGS=32, reg_addr_t typedef.
- Sub-module wb_scoreboard (32-bit pending vector, set/clear ports, 3 lookup outputs).
- Arbitration and wait counter stay in the top.

Test Plan:
- Reset then idle → rf_we=0, pending=0, a_ready=b_ready=1, err=0.
- A-only: a_valid, a_rd=5, a_wd=0xDEADBEEF → rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF same cycle; a_rd=0 → rf_we=0, a_ready=1.
- Scoreboard: issue rd=7; next cycle ra1=7 → raw_stall=1. B writes rd=7 with 0x1234 → pending[7] clears at that edge; following cycle raw_stall=0, regfile x7=0x1234. Re-issue rd=7 while pending → iss_stall=1, pending unchanged.
- Contention, MAX_WAIT=4: A and B valid every cycle → A wins cycles 0..3, B wins cycle 4 (a_ready=0, A holds), A wins cycle 5, counter back to 0.
- Errors: B write rd=9 with pending[9]=0 → err=1, stays 1 until rst. Separately, A write rd=3 with pending[3]=1 → err=1.
- Reset mid-operation: pending=0x0000_0180 and B stalled, assert rst one cycle → pending=0, wait_cnt=0, rf_we=0 during rst.
